// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 types, round constants, IV and bit-mixing functions
package sha256_pkg;
    typedef logic [31:0]      word_t;
    typedef logic [7:0][31:0] state_t;
    typedef logic [63:0][7:0] block_t;
    typedef enum logic [1:0] {IDLE, ROUND, FINAL} fsm_t;

    // Word 7 holds H0 so a packed state reads left to right as H0..H7.
    localparam state_t IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam word_t K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic word_t Sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t Sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction
endpackage

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 round
//   i_s : working state, word 7 = a ... word 0 = h
//   i_k : round constant Kt
//   i_w : schedule word Wt
//   o_s : working state after the round
module sha256_round
    import sha256_pkg::*;
(
    input  state_t i_s,
    input  word_t  i_k,
    input  word_t  i_w,
    output state_t o_s
);
    word_t w_t1, w_t2;

    assign w_t1 = i_s[0] + Sigma1(i_s[3]) + ch(i_s[3], i_s[2], i_s[1]) + i_k + i_w;
    assign w_t2 = Sigma0(i_s[7]) + maj(i_s[7], i_s[6], i_s[5]);
    assign o_s  = {w_t1 + w_t2, i_s[7], i_s[6], i_s[5], i_s[4] + w_t1, i_s[3], i_s[2], i_s[1]};
endmodule

// File: rtl/sha256_tumble.sv
// sha256_tumble: iterative SHA-256 engine, one round per clock
//   clk       : rising-edge clock
//   rst       : synchronous reset, active low
//   in_valid  : start pulse; restarts any job in flight
//   in_mode   : 0 = compress(in_state, in_data), 1 = SHA-256 of in_data[63:32]
//   in_state  : chaining state, word 7 = H0
//   in_data   : 512-bit block, byte 63 = first message byte
//   out_valid : one-cycle completion pulse
//   out_res   : digest / new chaining state, held until the next completion
//   out_busy  : high while a job is in flight
module sha256_tumble
    import sha256_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   in_valid,
    input  logic   in_mode,
    input  state_t in_state,
    input  block_t in_data,
    output logic   out_valid,
    output state_t out_res,
    output logic   out_busy
);
    fsm_t         r_fsm, w_nxt;
    logic [5:0]   r_t;
    state_t       r_h, r_ws, w_ws, w_sum, r_res;
    word_t        r_w [16];
    word_t        w_new;
    logic [511:0] w_blk;
    logic         w_load, w_step, w_fin, r_valid;

    // A start is only honoured outside reset (rst is active low).
    assign w_load = rst && in_valid;
    // hash32 builds the single padded block for a 256-bit message.
    assign w_blk  = in_mode ? {in_data[63:32], 8'h80, 184'h0, 64'h100} : in_data;
    // r_w[0] is Wt; the window slides one word per round.
    assign w_new  = sigma1(r_w[14]) + r_w[9] + sigma0(r_w[1]) + r_w[0];

    sha256_round u_round (.i_s(r_ws), .i_k(K[r_t]), .i_w(r_w[0]), .o_s(w_ws));

    always_ff @(posedge clk) begin
        if (!rst) r_fsm <= IDLE;
        else      r_fsm <= w_nxt;
    end

    always_comb begin
        w_nxt = in_valid ? ROUND :
                (r_fsm == ROUND && r_t == 6'd63) ? FINAL :
                (r_fsm == FINAL) ? IDLE : r_fsm;
    end

    always_comb begin
        w_step   = r_fsm == ROUND;
        w_fin    = r_fsm == FINAL;
        out_busy = r_fsm != IDLE;
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < 8; i++) w_sum[i] = r_h[i] + r_ws[i];
    end

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_h  <= in_mode ? IV : in_state;
            r_ws <= in_mode ? IV : in_state;
            for (int i = 0; i < 16; i++) r_w[i] <= w_blk[511 - 32*i -: 32];
        end else if (w_step) begin
            r_ws <= w_ws;
            for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
            r_w[15] <= w_new;
        end
    end

    // A start landing on the FINAL edge still lets the finishing job report.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_t     <= '0;
            r_valid <= 1'b0;
            r_res   <= '0;
        end else begin
            r_t     <= in_valid ? 6'd0 : w_step ? r_t + 6'd1 : r_t;
            r_valid <= w_fin;
            if (w_fin) r_res <= w_sum;
        end
    end

    assign out_valid = r_valid;
    assign out_res   = r_res;
endmodule

// File: tb/tb_sha256_tumble.sv
// tb_sha256_tumble: scoreboard bench for sha256_tumble against a behavioural SHA-256 model
module tb_sha256_tumble;
    logic              clk = 1'b0;
    logic              rst, in_valid, in_mode, out_valid, out_busy;
    logic [7:0][31:0]  in_state, out_res;
    logic [63:0][7:0]  in_data;

    sha256_tumble dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_mode(in_mode),
        .in_state(in_state), .in_data(in_data),
        .out_valid(out_valid), .out_res(out_res), .out_busy(out_busy));

    always #5 clk = ~clk;

    localparam logic [255:0] IVT     = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [511:0] ABC     = {32'h61626380, 416'h0, 64'h18};
    localparam logic [511:0] EMPTY   = {32'h80000000, 480'h0};
    localparam logic [255:0] ABC_D   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_D = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DABC_D  = 256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;
    localparam logic [255:0] ZERO_D  = 256'h66687aadf862bd776c8fc18b8e9f8e20089714856ee233b3902a591d0d5f2925;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    typedef struct {
        logic [255:0] res;
        int           start;
        int           due;
        string        nm;
    } exp_t;

    exp_t         q[$];
    int           n_cmp = 0, n_bad = 0, cyc = 0;
    logic         rst_edge = 1'b0;
    logic [255:0] last_res = '0;

    function automatic void chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Straight FIPS 180-4 compression: full 64-word schedule, a..h as v[0]..v[7].
    function automatic logic [255:0] ref_compress(input logic [255:0] st, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  t1, t2, s0, s1;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        for (int i = 0; i < 8; i++) v[i] = st[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = v[i] + st[255 - 32*i -: 32];
        return r;
    endfunction

    function automatic logic [255:0] ref_hash32(input logic [255:0] m);
        return ref_compress(IVT, {m, 8'h80, 184'h0, 64'd256});
    endfunction

    function automatic logic [255:0] r256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= rst;
    end

    // Monitor: owns reset discarding, pulse matching, latency and hold checks.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_edge) begin
            while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
            last_res = '0;
        end
        if (out_valid) begin
            if (q.size() == 0) chk("unexpected_valid", 256'(out_valid), 256'd0);
            else begin
                e = q.pop_front();
                chk({e.nm, "_res"}, out_res, e.res);
                chk({e.nm, "_latency"}, 256'(cyc - e.start), 256'd66);
                chk({e.nm, "_busy"}, 256'(out_busy), 256'(q.size() > 0));
                last_res = e.res;
            end
        end else begin
            chk("res_hold", out_res, last_res);
            if (q.size() > 0 && cyc > q[0].due) begin
                chk({q[0].nm, "_missing_valid"}, 256'(out_valid), 256'd1);
                void'(q.pop_front());
            end
        end
    end

    task automatic start(input logic m, input logic [255:0] st, input logic [511:0] blk,
                         input logic [255:0] exp, input string nm);
        exp_t e;
        // A job whose final edge is later than this start edge is aborted.
        while (q.size() > 0 && q[$].due > cyc + 1) void'(q.pop_back());
        e.res = exp; e.start = cyc; e.due = cyc + 66; e.nm = nm;
        q.push_back(e);
        in_valid = 1'b1; in_mode = m; in_state = st; in_data = blk;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [255:0] st, m;
        logic [511:0] blk;
        logic         md;
        rst = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_state = '0; in_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_valid", 256'(out_valid), 256'd0);
        chk("reset_busy", 256'(out_busy), 256'd0);
        chk("reset_res", out_res, 256'd0);
        rst = 1'b1;
        @(negedge clk);

        start(1'b0, IVT, ABC, ABC_D, "abc");
        chk("busy_mid", 256'(out_busy), 256'd1);
        drain();
        start(1'b0, IVT, EMPTY, EMPTY_D, "empty");
        drain();
        start(1'b1, r256(), {ABC_D, r256()}, DABC_D, "hash32_abc");
        drain();
        start(1'b1, r256(), {256'h0, r256()}, ZERO_D, "hash32_zero");
        drain();

        start(1'b0, IVT, ABC, ABC_D, "aborted");
        repeat (29) @(negedge clk);
        start(1'b0, IVT, EMPTY, EMPTY_D, "restart");
        drain();

        st = r256(); blk = {r256(), r256()};
        start(1'b0, st, blk, ref_compress(st, blk), "final_edge_a");
        repeat (64) @(negedge clk);
        m = r256();
        start(1'b1, r256(), {m, r256()}, ref_hash32(m), "final_edge_b");
        drain();

        start(1'b0, IVT, ABC, ABC_D, "reset_victim");
        repeat (39) @(negedge clk);
        rst = 1'b0; in_valid = 1'b1; in_data = {r256(), r256()};
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        chk("midreset_valid", 256'(out_valid), 256'd0);
        chk("midreset_busy", 256'(out_busy), 256'd0);
        chk("midreset_res", out_res, 256'd0);
        repeat (80) @(negedge clk);
        chk("postreset_busy", 256'(out_busy), 256'd0);
        start(1'b0, IVT, ABC, ABC_D, "abc_after_reset");
        drain();

        for (int n = 0; n < 6; n++) begin
            md = 1'($urandom_range(1));
            st = r256(); blk = {r256(), r256()};
            start(md, st, blk, md ? ref_hash32(blk[511:256]) : ref_compress(st, blk), $sformatf("rand%0d", n));
            repeat ($urandom_range(5)) @(negedge clk);
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sha256_tumble.md
SHA256_TUMBLE -- requirements
Module: sha256_tumble

Interface
REQ-001 The block SHALL have no parameters; one round per clock is fixed.
REQ-002 The block SHALL use one clock and a synchronous, active-low reset: clk, rst.
REQ-003 The block SHALL have port clk: input, 1 bit, rising-edge clock.
REQ-004 The block SHALL have port rst: input, 1 bit, synchronous active-low reset.
REQ-005 The block SHALL have port in_valid: input, 1 bit, start pulse; inputs are sampled on the clk edge where in_valid=1.
REQ-006 The block SHALL have port in_mode: input, 1 bit; 0=compress, 1=hash32.
REQ-007 The block SHALL have port in_state: input, [7:0][31:0], chaining state; word 7 (bits 255:224) = H0.
REQ-008 The block SHALL have port in_data: input, [63:0][7:0], 512-bit block; byte 63 (bits 511:504) = first message byte, big-endian words.
REQ-009 The block SHALL have port out_valid: output, 1 bit, one-cycle done pulse.
REQ-010 The block SHALL have port out_res: output, [7:0][31:0], digest/new state; word 7 = H0.
REQ-011 The block SHALL have port out_busy: output, 1 bit, high while a computation is in flight.

Function
REQ-012 In compress mode, out_res SHALL equal in_state + SHA-256 compression(in_state, in_data), with per-word mod 2^32 add.
REQ-013 In hash32 mode, the block SHALL compute SHA-256 of the 32-byte message in_data[63:32]. Initial state = FIPS 180-4 IV; padded block = message, 0x80, 23 zero bytes, 64-bit length 0x100. in_state and in_data[31:0] are ignored.
REQ-014 On in_valid, the block SHALL register its inputs, load a-h from the initial state and W0..W15 from the block, and set out_busy=1.
REQ-015 The block SHALL perform exactly one round per clock, 64 rounds, with an on-the-fly 16-word rolling message schedule (Wt = s1(Wt-2)+Wt-7+s0(Wt-15)+Wt-16).
REQ-016 The final-add cycle SHALL update out_res and pulse out_valid=1 for exactly one cycle, exactly 66 clocks after the in_valid edge. out_busy SHALL fall in the same cycle.
REQ-017 The FSM states SHALL be IDLE -> ROUND (t=0..63) -> FINAL -> IDLE. in_valid is accepted in any state.
REQ-018 If in_valid arrives while busy, the block SHALL abort the current job, emit no out_valid for it, and restart with the new inputs. Latency counts from the new edge.
REQ-019 out_res SHALL hold its last value until the next FINAL. It is undefined-free: 0 until the first completion.
REQ-020 in_valid asserted on the same edge as FINAL SHALL still produce out_valid/out_res for the completing job, and the new job SHALL start on that edge.
REQ-021 All arithmetic SHALL be 32-bit modulo 2^32 with no saturation. Round counter is 6 bits plus FINAL state, with no wrap into a new job.

Reset
REQ-022 While rst=0 at a clk edge, the block SHALL go to IDLE with out_valid=0, out_busy=0, out_res=0 and round counter=0. Any in-flight job is discarded.
REQ-023 in_valid SHALL be ignored while rst=0. Reset mid-job SHALL produce no out_valid afterwards.

Structure
REQ-024 The shared package sha256_pkg SHALL hold: K[0:63] constants, IV[7:0], word typedefs (word_t, state_t, block_t), and functions ch, maj, Sigma0/1, sigma0/1.
REQ-025 There SHALL be one combinational sub-module, sha256_round (a-h, Kt, Wt in; next a-h out). The FSM and schedule remain in sha256_tumble.

Verification
REQ-026 Stimulus: compress mode, in_state=IV, block="abc" padded (61626380, zeros, length 0x18). Required response: out_res = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, with out_valid exactly 66 cycles after start.
REQ-027 Stimulus: compress mode, IV, block 0x80 followed by zeros. Required response: out_res = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
REQ-028 Stimulus: hash32 mode, in_data[63:32] = ba7816bf...f20015ad. Required response: out_res = 4f8b42c2 2dd3729b 519ba6f6 8d2da7cc 5b2d606d 05daed5a d5128cc0 3e6c6358 (double SHA-256 of "abc").
REQ-029 Stimulus: hash32 mode, 32 zero bytes. Required response: out_res = 66687aad f862bd77 6c8fc18b 8e9f8e20 08971485 6ee233b3 902a591d 0d5f2925.
REQ-030 Stimulus: start the "abc" job, then re-pulse in_valid with the empty-message block at cycle 30. Required response: one out_valid only, 66 cycles after the second start, with the e3b0c442... value.
REQ-031 Stimulus: start a job, assert rst=0 at cycle 40 for 1 cycle. Required response: out_valid never asserts, out_res=0, out_busy=0. A subsequent "abc" job SHALL give the REQ-026 result.
